// File: rtl/fir_pkg.sv
// Shared constants for the FIR filter: default coefficient table, clog2 and
// accumulator width derivation.
package fir_pkg;

  localparam int DEF_TAPS = 43;

  localparam int DEF_COEF [DEF_TAPS] = '{
    2, 4, 4, 2, -3, -10, -14, -14, -6, 7, 19, 22, 12, -11, -36, -48, -35, 11,
    83, 161, 221, 244, 221, 161, 83, 11, -35, -48, -36, -11, 12, 22, 19, 7,
    -6, -14, -14, -10, -3, 2, 4, 4, 2
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Wide enough that summing NTAPS full-scale products can never wrap.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + clog2(ntaps);
  endfunction

  // Taps beyond the default table come out of reset as zero.
  function automatic int default_coef(input int k);
    if (k >= 0 && k < DEF_TAPS) return DEF_COEF[k];
    return 0;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register bank: reset-loaded defaults, indexed write port and
// combinational readback. Out-of-range indices neither write nor read.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int NTAPS = 43,
  parameter int CW    = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wstrobe_i,
  input  logic [5:0]                  waddr_i,
  input  logic [CW-1:0]               wdata_i,
  output logic [CW-1:0]               rdata_o,
  output logic [NTAPS-1:0][CW-1:0]    coef_o
);

  logic [NTAPS-1:0][CW-1:0] coef_q;

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NTAPS; k++) coef_q[k] <= CW'(default_coef(k));
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (wstrobe_i && waddr_i == 6'(k)) coef_q[k] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (waddr_i == 6'(k)) rdata_o = coef_q[k];
    end
  end

  assign coef_o = coef_q;

endmodule

// File: rtl/fir_param.sv
// Parameterised 3-stage pipelined FIR (delay line, product bank, adder tree),
// all state on the falling clock edge. Define FIR_SAT_EN to saturate dout.
module fir_param
  import fir_pkg::*;
#(
  parameter int NTAPS  = 43,
  parameter int DW     = 32,
  parameter int CW     = 32,
  parameter int OSHIFT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flagin,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout,
  output logic                 flagout,
  input  logic                 wstrobe,
  input  logic [5:0]           waddr,
  input  logic [CW-1:0]        wdata,
  output logic [CW-1:0]        rdata
);

  localparam int ACCW = acc_width(DW, CW, NTAPS);
  localparam int PW   = DW + CW;

  logic [NTAPS-1:0][CW-1:0] coef_w;
  logic signed [DW-1:0]     sr_q   [NTAPS];
  logic signed [PW-1:0]     prod_q [NTAPS];
  logic signed [ACCW-1:0]   acc_q;
  logic signed [ACCW-1:0]   sum_d;
  logic                     v1_q, v2_q, v3_q;

  fir_coef_bank #(.NTAPS(NTAPS), .CW(CW)) u_coef_bank (
    .clk_i     (clk),
    .rst_i     (reset),
    .wstrobe_i (wstrobe),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .coef_o    (coef_w)
  );

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NTAPS; k++) sum_d = sum_d + ACCW'(prod_q[k]);
  end

  // Sampling edge is stage 1; flagout rises with the stage-3 accumulator load.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        sr_q[k]   <= '0;
        prod_q[k] <= '0;
      end
      acc_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
    end else begin
      v1_q <= flagin;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (flagin) begin
        sr_q[0] <= din;
        for (int k = 1; k < NTAPS; k++) sr_q[k] <= sr_q[k-1];
      end
      // Products see the coefficient as it stood before this edge's write.
      if (v1_q) begin
        for (int k = 0; k < NTAPS; k++) begin
          prod_q[k] <= PW'(sr_q[k]) * PW'($signed(coef_w[k]));
        end
      end
      if (v2_q) acc_q <= sum_d;
    end
  end

  assign flagout = v3_q;

`ifdef FIR_SAT_EN
  localparam int HB = ACCW - OSHIFT - DW + 1;
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
  logic ovf;

  // Shifted value fits only if every bit above the output MSB matches the sign.
  assign ovf = acc_q[ACCW-1:OSHIFT+DW-1] != {HB{acc_q[ACCW-1]}};

  always_comb begin
    dout = acc_q[OSHIFT+DW-1:OSHIFT];
    if (ovf) dout = acc_q[ACCW-1] ? SAT_MIN : SAT_MAX;
  end
`else
  assign dout = acc_q[OSHIFT+DW-1:OSHIFT];
`endif

  logic acc_unused;
  assign acc_unused = ^acc_q;

endmodule

// File: tb/tb_fir_param.sv
// Self-checking bench for fir_param: randomized samples and coefficient writes
// scored against an arithmetic convolution model, plus a DW=16 saturation unit.
module tb_fir_param;

  localparam int NT  = 43;
  localparam int DW  = 32;
  localparam int OSH = 8;

  localparam int TABLE [NT] = '{
    2, 4, 4, 2, -3, -10, -14, -14, -6, 7, 19, 22, 12, -11, -36, -48, -35, 11,
    83, 161, 221, 244, 221, 161, 83, 11, -35, -48, -36, -11, 12, 22, 19, 7,
    -6, -14, -14, -10, -3, 2, 4, 4, 2
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               flagin, wstrobe, flagout;
  logic signed [31:0] din, dout, rdata;
  logic [5:0]         waddr;
  logic [31:0]        wdata;

  logic               flagin16, flagout16;
  logic signed [15:0] din16, dout16;
  logic [31:0]        rdata16;
  logic               wstrobe16 = 1'b0;
  logic [5:0]         waddr16 = '0;
  logic [31:0]        wdata16 = '0;

  fir_param dut (
    .clk(clk), .reset(reset), .flagin(flagin), .din(din), .dout(dout),
    .flagout(flagout), .wstrobe(wstrobe), .waddr(waddr), .wdata(wdata),
    .rdata(rdata)
  );

  fir_param #(.DW(16), .OSHIFT(0)) dut16 (
    .clk(clk), .reset(reset), .flagin(flagin16), .din(din16), .dout(dout16),
    .flagout(flagout16), .wstrobe(wstrobe16), .waddr(waddr16), .wdata(wdata16),
    .rdata(rdata16)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int                 mcoef [NT];
  int                 hist[$];
  logic signed [31:0] exp_q[$];
  int                 cyc_q[$];
  int                 cyc = 0;
  int                 n_flag = 0;
  int                 n_flag16 = 0;
  logic signed [31:0] last_exp = '0;

  always @(negedge clk) cyc++;

  function automatic logic signed [31:0] model_out();
    logic signed [127:0] acc;
    acc = '0;
    for (int k = 0; k < hist.size(); k++) acc += 128'(hist[k]) * 128'(mcoef[k]);
    return acc[OSH+DW-1:OSH];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) mcoef[k] = TABLE[k];
    hist.delete();
    exp_q.delete();
    cyc_q.delete();
  endtask

  // ---------------- driver ----------------
  // A coefficient written on a sample's own edge is already in effect when
  // that sample's products are taken one edge later.
  task automatic drive(input logic fl, input logic signed [31:0] d, input logic ws,
                       input logic [5:0] wa, input logic [31:0] wd);
    @(posedge clk);
    flagin = fl; din = d; wstrobe = ws; waddr = wa; wdata = wd;
    if (ws && wa < NT) mcoef[wa] = wd;
    if (fl) begin
      hist.push_front(d);
      if (hist.size() > NT) void'(hist.pop_back());
      exp_q.push_back(model_out());
      cyc_q.push_back(cyc + 3);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, waddr, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check_val("drain_empty", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic impulse(input logic signed [31:0] amp);
    drive(1'b1, amp, 1'b0, 6'd0, '0);
    for (int i = 0; i < NT - 1; i++) drive(1'b1, '0, 1'b0, 6'd0, '0);
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (!reset && flagout) begin
      n_flag++;
      if (exp_q.size() == 0) check_val("spurious_flagout", 1, 0);
      else begin
        last_exp = exp_q.pop_front();
        check_val("dout", dout, last_exp);
        check_val("latency_cycle", cyc, cyc_q.pop_front());
      end
    end
    if (!reset && flagout16) n_flag16++;
  end

  // ---------------- stimulus ----------------
  initial begin
    int snap;
    logic signed [127:0] acc16;
    logic signed [15:0]  exp16;

    flagin = 0; din = '0; wstrobe = 0; waddr = '0; wdata = '0;
    flagin16 = 0; din16 = '0;
    model_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    check_val("rst_dout", dout, 0);
    check_val("rst_flagout", flagout, 0);
    waddr = 6'd21; #1 check_val("rst_rdata21", rdata, 244);
    waddr = 6'd0;  #1 check_val("rst_rdata0", rdata, 2);
    @(posedge clk) reset = 1'b0;

    // impulse reproduces the default table
    impulse(256);
    drain();
    idle(3);
    check_val("dout_hold", dout, last_exp);

    // isolated sample, then 10 back-to-back
    snap = n_flag;
    drive(1'b1, $urandom, 1'b0, 6'd0, '0);
    drain();
    check_val("single_flagout_count", n_flag - snap, 1);
    snap = n_flag;
    for (int i = 0; i < 10; i++) drive(1'b1, $urandom, 1'b0, 6'd0, '0);
    drain();
    check_val("burst_flagout_count", n_flag - snap, 10);

    // coefficient write / readback / out-of-range
    drive(1'b0, '0, 1'b1, 6'd21, 32'd1000);
    drive(1'b0, '0, 1'b0, 6'd21, '0);
    #1 check_val("rdata_w21", rdata, 1000);
    drive(1'b0, '0, 1'b1, 6'd50, 32'd123);
    drive(1'b0, '0, 1'b0, 6'd50, '0);
    #1 check_val("rdata_oob", rdata, 0);
    for (int k = 0; k < NT; k++) begin
      waddr = 6'(k);
      #1 check_val("rdata_bank", rdata, mcoef[k]);
    end
    impulse(256);
    drain();

    // write landing on the product-capture edge uses the old coefficient
    drive(1'b1, 32'sd1000, 1'b0, 6'd0, '0);
    drive(1'b0, '0, 1'b1, 6'd0, 32'd77);
    drive(1'b1, 32'sd5, 1'b0, 6'd0, '0);
    drain();

    // randomized samples and coefficient writes
    for (int i = 0; i < 300; i++) begin
      int wd;
      wd = $urandom_range(0, 2000) - 1000;
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
            6'($urandom_range(0, 63)), wd);
    end
    drain();

    // reset mid-stream discards in-flight samples
    snap = n_flag;
    drive(1'b1, 32'sd12345, 1'b0, 6'd21, '0);
    @(posedge clk);
    reset = 1'b1; flagin = 0; waddr = 6'd21;
    model_reset();
    #1 check_val("midrst_dout", dout, 0);
    check_val("midrst_flagout", flagout, 0);
    check_val("midrst_rdata21", rdata, 244);
    repeat (2) @(posedge clk);
    reset = 1'b0;
    idle(6);
    check_val("midrst_no_flagout", n_flag - snap, 0);
    check_val("post_rst_dout", dout, 0);

    // DW=16, OSHIFT=0 unit: 43 samples of full-scale positive input
    for (int i = 0; i < NT; i++) begin
      @(posedge clk); flagin16 = 1'b1; din16 = 16'sd32767;
    end
    @(posedge clk); flagin16 = 1'b0;
    for (int i = 0; i < 20 && n_flag16 < NT; i++) @(posedge clk);
    check_val("sat_flagout_count", n_flag16, NT);
    acc16 = '0;
    for (int k = 0; k < NT; k++) acc16 += 128'(32767) * 128'(TABLE[k]);
`ifdef FIR_SAT_EN
    if (acc16 > 128'sd32767) exp16 = 16'sd32767;
    else if (acc16 < -128'sd32768) exp16 = -16'sd32768;
    else exp16 = acc16[15:0];
`else
    exp16 = acc16[15:0];
`endif
    check_val("dout16_full_scale", dout16, exp16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_param.md
FIR_PARAM -- requirements
Module: fir_param

Interface
REQ-001 The module SHALL have parameter NTAPS, default 43, meaning the tap count (range 2..64).
REQ-002 The module SHALL have parameter DW, default 32, meaning the signed input and output sample width.
REQ-003 The module SHALL have parameter CW, default 32, meaning the signed coefficient width.
REQ-004 The module SHALL have parameter OSHIFT, default 8, meaning the accumulator bit index that becomes the output LSB.
REQ-005 The module SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state updates on its falling edge
- reset  in  1  asynchronous, active-high reset
- flagin  in  1  din valid strobe
- din  in  DW  signed input sample
- dout  out  DW  signed filtered sample
- flagout  out  1  dout valid strobe
- wstrobe  in  1  coefficient write enable
- waddr  in  6  coefficient index
- wdata  in  CW  coefficient write data
- rdata  out  CW  coefficient readback

Function
REQ-006 The block SHALL compute y[n] = sum over k=0..NTAPS-1 of coef[k]*x[n-k], where x advances only on samples accepted with flagin=1.
REQ-007 The accumulator SHALL be signed, ACCW = DW+CW+clog2(NTAPS) bits wide, and SHALL never wrap internally.
REQ-008 Pipeline stage 1 (flagin=1) SHALL shift din into the delay line: sr[0]<=din and sr[k]<=sr[k-1].
REQ-009 Stage 2 SHALL register all NTAPS products, enabled by the stage-1 valid.
REQ-010 Stage 3 SHALL register the product sum, enabled by the stage-2 valid, and SHALL drive dout = acc[OSHIFT+DW-1:OSHIFT].
REQ-011 flagout SHALL pulse for exactly one cycle, 3 falling edges after the edge that sampled flagin=1; latency is fixed at 3.
REQ-012 The block SHALL accept back-to-back samples at full rate (flagin=1 every cycle) with one flagout per flagin and no bubbles.
REQ-013 When a stage has no valid, it SHALL hold its registers, and dout SHALL hold its last value.
REQ-014 A write with wstrobe=1 and waddr<NTAPS SHALL update coef[waddr] on the falling edge; writes with waddr>=NTAPS SHALL be ignored.
REQ-015 On a simultaneous write and stage-2 product capture, the products SHALL use the pre-write coefficient; the new value applies from the next edge.
REQ-016 rdata SHALL be combinational coef[waddr], and SHALL be 0 when waddr>=NTAPS.

Reset
REQ-017 Reset SHALL clear the delay line, product registers, accumulator, dout=0, flagout=0 and all pipeline valids, and SHALL load coef[k] with the package default table.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight samples; no flagout SHALL appear for samples accepted before reset.

Configuration
REQ-019 With FIR_SAT_EN defined, dout SHALL saturate to +2^(DW-1)-1 / -2^(DW-1) whenever acc>>>OSHIFT exceeds the DW signed range.
REQ-020 Without FIR_SAT_EN, dout SHALL be the plain bit-slice of REQ-010 and overflow SHALL wrap.

Structure
REQ-021 A shared package fir_pkg SHALL hold the 43-entry default coefficient table (2,4,4,2,-3,-10,-14,-14,-6,7,19,22,12,-11,-36,-48,-35,11,83,161,221,244, then mirrored), a clog2 function, and the ACCW derivation.
REQ-022 For NTAPS<43 the default table SHALL be truncated; for NTAPS>43 the extra entries SHALL reset to 0.
REQ-023 The coefficient register bank with its write and readback port SHALL be a sub-module, fir_coef_bank; the datapath SHALL remain in fir_param.

Verification
REQ-024 Impulse test: after reset, din=256 for one flagged sample, then 42 flagged zeros -> the flagout-qualified dout sequence SHALL be 2,4,4,2,-3,-10,...,4,2 (the default table).
REQ-025 Latency test: a single flagin -> flagout high exactly 3 falling edges later, for one cycle; flagin held high for 10 cycles -> 10 consecutive flagout cycles.
REQ-026 Coefficient test: write coef[21]=1000 then read it back -> rdata=1000; write with waddr=50 -> no state change and rdata=0; a subsequent impulse of 256 -> tap-21 output equals 1000.
REQ-027 Saturation test (DW=16, OSHIFT=0, FIR_SAT_EN): 43 flagged samples of +32767 -> dout=32767; same run without the macro -> dout equals the wrapped low 16 bits of the accumulator.
REQ-028 Reset test: assert reset one cycle after a flagged sample -> no flagout follows; dout=0; rdata at waddr=21 returns 244.
